// File: rtl/sdf_r2_bf_stage256_if.sv
// Signal bundle between the radix-2 SDF butterfly stage and its surroundings:
// upstream samples, the external delay line, and the stage output stream.
interface sdf_r2_bf_stage256_if #(
    parameter int WIDTH = 24,
    parameter int HALF  = 256
);
    localparam int TW = $clog2(HALF);

    logic             in_valid;
    logic [WIDTH-1:0] din_r;
    logic [WIDTH-1:0] din_i;
    logic [WIDTH-1:0] sr_dout_r;
    logic [WIDTH-1:0] sr_dout_i;
    logic             sr_valid;
    logic [WIDTH-1:0] sr_din_r;
    logic [WIDTH-1:0] sr_din_i;
    logic             out_valid;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_i;
    logic             out_diff;
    logic [TW-1:0]    tw_idx;

    // The butterfly stage drives the delay-line input and the output stream.
    modport master (
        input  in_valid, din_r, din_i, sr_dout_r, sr_dout_i,
        output sr_valid, sr_din_r, sr_din_i,
        output out_valid, dout_r, dout_i, out_diff, tw_idx
    );

    modport slave (
        output in_valid, din_r, din_i, sr_dout_r, sr_dout_i,
        input  sr_valid, sr_din_r, sr_din_i,
        input  out_valid, dout_r, dout_i, out_diff, tw_idx
    );
endinterface

// File: rtl/sdf_r2_bf_stage256.sv
// Radix-2 SDF butterfly/control element for the N/2 stage of a 1024-point FFT.
// Feeds and drains an external HALF-deep delay line; emits sums then differences.
module sdf_r2_bf_stage256 #(
    parameter int WIDTH = 24,
    parameter int HALF  = 256,
    parameter int SCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sdf_r2_bf_stage256_if.master  bus
);
    localparam int TW = $clog2(HALF);
    localparam int CW = TW + 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             run;
    logic             primed;
    logic             active;
    logic             phase;

    logic [WIDTH-1:0] din_eff_r;
    logic [WIDTH-1:0] din_eff_i;
    logic [WIDTH:0]   sum_r;
    logic [WIDTH:0]   sum_i;
    logic [WIDTH:0]   diff_r;
    logic [WIDTH:0]   diff_i;
    logic [WIDTH-1:0] sum_s_r;
    logic [WIDTH-1:0] sum_s_i;
    logic [WIDTH-1:0] diff_s_r;
    logic [WIDTH-1:0] diff_s_i;
    logic             unused_bits;

    logic [WIDTH-1:0] sel_r;
    logic [WIDTH-1:0] sel_i;
    logic             sel_diff;
    logic [TW-1:0]    sel_tw;
    logic [WIDTH-1:0] sr_in_r;
    logic [WIDTH-1:0] sr_in_i;

    assign run    = (state != IDLE);
    assign primed = (state == STREAM);
    // Gated by rst_n so the delay line does not shift while the stage is held in reset.
    assign active = rst_n & (bus.in_valid | run);
    assign phase  = cnt[CW-1];

    assign din_eff_r = bus.in_valid ? bus.din_r : '0;
    assign din_eff_i = bus.in_valid ? bus.din_i : '0;

    assign sum_r  = {bus.sr_dout_r[WIDTH-1], bus.sr_dout_r} + {din_eff_r[WIDTH-1], din_eff_r};
    assign sum_i  = {bus.sr_dout_i[WIDTH-1], bus.sr_dout_i} + {din_eff_i[WIDTH-1], din_eff_i};
    assign diff_r = {bus.sr_dout_r[WIDTH-1], bus.sr_dout_r} - {din_eff_r[WIDTH-1], din_eff_r};
    assign diff_i = {bus.sr_dout_i[WIDTH-1], bus.sr_dout_i} - {din_eff_i[WIDTH-1], din_eff_i};

    // SCALE=1 halves with truncation toward -inf; SCALE=0 wraps to WIDTH bits.
    assign sum_s_r  = (SCALE != 0) ? sum_r[WIDTH:1]  : sum_r[WIDTH-1:0];
    assign sum_s_i  = (SCALE != 0) ? sum_i[WIDTH:1]  : sum_i[WIDTH-1:0];
    assign diff_s_r = (SCALE != 0) ? diff_r[WIDTH:1] : diff_r[WIDTH-1:0];
    assign diff_s_i = (SCALE != 0) ? diff_i[WIDTH:1] : diff_i[WIDTH-1:0];
    assign unused_bits = ^{sum_r, sum_i, diff_r, diff_i};

    assign bus.sr_valid = active;
    assign bus.sr_din_r = sr_in_r;
    assign bus.sr_din_i = sr_in_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_r      = bus.sr_dout_r;
        sel_i      = bus.sr_dout_i;
        sel_diff   = 1'b1;
        sel_tw     = cnt[TW-1:0];
        sr_in_r    = din_eff_r;
        sr_in_i    = din_eff_i;

        if (phase) begin
            sel_r    = sum_s_r;
            sel_i    = sum_s_i;
            sel_diff = 1'b0;
            sel_tw   = '0;
            sr_in_r  = diff_s_r;
            sr_in_i  = diff_s_i;
        end

        case (state)
            IDLE:    if (active) state_next = FILL;
            FILL:    if (active && phase) state_next = STREAM;
            STREAM:  state_next = STREAM;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.dout_r    <= '0;
            bus.dout_i    <= '0;
            bus.out_diff  <= 1'b0;
            bus.tw_idx    <= '0;
        end else begin
            bus.out_valid <= active & (phase | primed);
            if (active) begin
                cnt          <= cnt + 1'b1;
                bus.dout_r   <= sel_r;
                bus.dout_i   <= sel_i;
                bus.out_diff <= sel_diff;
                bus.tw_idx   <= sel_tw;
            end
        end
    end
endmodule

// File: tb/tb_sdf_r2_bf_stage256.sv
// Directed bench for sdf_r2_bf_stage256: models the 256-deep delay line, logs
// every valid output and compares against hand-derived butterfly results.
module tb_sdf_r2_bf_stage256;
    localparam int WIDTH = 24;
    localparam int HALF  = 256;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] i;
        logic             d;
        logic [7:0]       tw;
        int               cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    rec_t q0[$];
    rec_t q1[$];

    logic [WIDTH-1:0] dl0_r [HALF];
    logic [WIDTH-1:0] dl0_i [HALF];
    logic [WIDTH-1:0] dl1_r [HALF];
    logic [WIDTH-1:0] dl1_i [HALF];

    sdf_r2_bf_stage256_if #(.WIDTH(WIDTH), .HALF(HALF)) bus0 ();
    sdf_r2_bf_stage256_if #(.WIDTH(WIDTH), .HALF(HALF)) bus1 ();

    sdf_r2_bf_stage256 #(.WIDTH(WIDTH), .HALF(HALF), .SCALE(1)) dut_scaled (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    sdf_r2_bf_stage256 #(.WIDTH(WIDTH), .HALF(HALF), .SCALE(0)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    always #5 clk = ~clk;

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.din_r     = bus0.din_r;
    assign bus1.din_i     = bus0.din_i;
    assign bus0.sr_dout_r = dl0_r[HALF-1];
    assign bus0.sr_dout_i = dl0_i[HALF-1];
    assign bus1.sr_dout_r = dl1_r[HALF-1];
    assign bus1.sr_dout_i = dl1_i[HALF-1];

    // Behavioural delay lines, one per DUT.
    always @(posedge clk) begin
        if (bus0.sr_valid) begin
            for (int j = HALF - 1; j > 0; j--) begin
                dl0_r[j] <= dl0_r[j-1];
                dl0_i[j] <= dl0_i[j-1];
            end
            dl0_r[0] <= bus0.sr_din_r;
            dl0_i[0] <= bus0.sr_din_i;
        end
        if (bus1.sr_valid) begin
            for (int j = HALF - 1; j > 0; j--) begin
                dl1_r[j] <= dl1_r[j-1];
                dl1_i[j] <= dl1_i[j-1];
            end
            dl1_r[0] <= bus1.sr_din_r;
            dl1_i[0] <= bus1.sr_din_i;
        end
    end

    always @(negedge clk) begin
        if (bus0.out_valid)
            q0.push_back(rec_t'{r: bus0.dout_r, i: bus0.dout_i, d: bus0.out_diff, tw: bus0.tw_idx, cyc: cyc});
        if (bus1.out_valid)
            q1.push_back(rec_t'{r: bus1.dout_r, i: bus1.dout_i, d: bus1.out_diff, tw: bus1.tw_idx, cyc: cyc});
        cyc = cyc + 1;
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] i);
        bus0.in_valid = v;
        bus0.din_r    = r;
        bus0.din_i    = i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive(1'b0, '0, '0);
        drive(1'b0, '0, '0);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.din_r    = 24'd5;
        bus0.din_i    = 24'd7;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.dout_r !== '0) begin n_bad++; $display("[TB] FAIL reset_dout_r got %h want 0", bus0.dout_r); end
        n_cmp++; if (bus0.dout_i !== '0) begin n_bad++; $display("[TB] FAIL reset_dout_i got %h want 0", bus0.dout_i); end
        n_cmp++; if (bus0.out_diff !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_diff got %b want 0", bus0.out_diff); end
        n_cmp++; if (bus0.tw_idx !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_tw_idx got %0d want 0", bus0.tw_idx); end
        n_cmp++; if (bus0.sr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_sr_valid got %b want 0", bus0.sr_valid); end
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wrap_out_valid got %b want 0", bus1.out_valid); end
        drive(1'b0, '0, '0);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    // Shared by the ramp and mid-frame-reset scenarios: x[n]=n from cycle c0.
    task automatic check_ramp(input string tag, input int c0);
        logic [WIDTH-1:0] er;
        logic [WIDTH-1:0] ei;
        logic             ed;
        logic [7:0]       et;
        n_cmp++;
        if (q0.size() < 512) begin
            n_bad++;
            $display("[TB] FAIL %s_count got %0d want >=512", tag, q0.size());
        end else begin
            n_cmp++;
            if (q0[0].cyc !== c0 + 257) begin
                n_bad++;
                $display("[TB] FAIL %s_latency got %0d want %0d", tag, q0[0].cyc - c0, 257);
            end
            for (int k = 0; k < 512; k++) begin
                er = (k < 256) ? 24'(k + 128) : 24'(-128);
                ei = '0;
                ed = (k >= 256);
                et = (k < 256) ? 8'd0 : 8'(k - 256);
                n_cmp++;
                if ({q0[k].r, q0[k].i, q0[k].d, q0[k].tw} !== {er, ei, ed, et}) begin
                    n_bad++;
                    $display("[TB] FAIL %s k=%0d got r=%h i=%h d=%b tw=%0d want r=%h i=%h d=%b tw=%0d",
                             tag, k, q0[k].r, q0[k].i, q0[k].d, q0[k].tw, er, ei, ed, et);
                end
            end
        end
    endtask

    task automatic test_ramp;
        int c0;
        do_reset();
        c0 = cyc;
        for (int n = 0; n < 512; n++) drive(1'b1, 24'(n), '0);
        repeat (260) drive(1'b0, '0, '0);
        check_ramp("ramp", c0);
    endtask

    task automatic test_complex;
        logic [WIDTH-1:0] er;
        logic [WIDTH-1:0] ei;
        logic [7:0]       et;
        do_reset();
        for (int n = 0; n < 512; n++) drive(1'b1, 24'd1000, 24'(-2000));
        repeat (260) drive(1'b0, '0, '0);
        n_cmp++;
        if (q0.size() < 512) begin
            n_bad++;
            $display("[TB] FAIL complex_count got %0d want >=512", q0.size());
        end else begin
            for (int k = 0; k < 512; k++) begin
                er = (k < 256) ? 24'd1000 : 24'd0;
                ei = (k < 256) ? 24'(-2000) : 24'd0;
                et = (k < 256) ? 8'd0 : 8'(k - 256);
                n_cmp++;
                if ({q0[k].r, q0[k].i, q0[k].d, q0[k].tw} !== {er, ei, (k >= 256), et}) begin
                    n_bad++;
                    $display("[TB] FAIL complex k=%0d got r=%h i=%h d=%b tw=%0d want r=%h i=%h tw=%0d",
                             k, q0[k].r, q0[k].i, q0[k].d, q0[k].tw, er, ei, et);
                end
            end
        end
    endtask

    task automatic test_overflow;
        logic [WIDTH-1:0] ew;
        logic [WIDTH-1:0] es;
        logic [7:0]       et;
        do_reset();
        for (int n = 0; n < 512; n++) drive(1'b1, (n < 256) ? 24'h7FFFFF : 24'h000001, '0);
        repeat (260) drive(1'b0, '0, '0);
        n_cmp++;
        if (q1.size() < 512 || q0.size() < 512) begin
            n_bad++;
            $display("[TB] FAIL overflow_count got %0d/%0d want >=512", q1.size(), q0.size());
        end else begin
            for (int k = 0; k < 512; k++) begin
                ew = (k < 256) ? 24'h800000 : 24'h7FFFFE;
                es = (k < 256) ? 24'h400000 : 24'h3FFFFF;
                et = (k < 256) ? 8'd0 : 8'(k - 256);
                n_cmp++;
                if ({q1[k].r, q1[k].i, q1[k].d, q1[k].tw} !== {ew, 24'd0, (k >= 256), et}) begin
                    n_bad++;
                    $display("[TB] FAIL overflow_wrap k=%0d got r=%h i=%h d=%b tw=%0d want r=%h i=0 tw=%0d",
                             k, q1[k].r, q1[k].i, q1[k].d, q1[k].tw, ew, et);
                end
                n_cmp++;
                if ({q0[k].r, q0[k].i, q0[k].d, q0[k].tw} !== {es, 24'd0, (k >= 256), et}) begin
                    n_bad++;
                    $display("[TB] FAIL overflow_scaled k=%0d got r=%h i=%h d=%b tw=%0d want r=%h i=0 tw=%0d",
                             k, q0[k].r, q0[k].i, q0[k].d, q0[k].tw, es, et);
                end
            end
        end
    endtask

    // Frame f carries real n+512f and imag -f; blocks alternate sums/diffs.
    task automatic test_back_to_back;
        int               c0;
        int               blk;
        int               k;
        int               f;
        logic [WIDTH-1:0] er;
        logic [WIDTH-1:0] ei;
        logic [7:0]       et;
        do_reset();
        c0 = cyc;
        for (int fr = 0; fr < 3; fr++)
            for (int n = 0; n < 512; n++) drive(1'b1, 24'(n + 512 * fr), 24'(-fr));
        repeat (260) drive(1'b0, '0, '0);
        n_cmp++;
        if (q0.size() < 1536) begin
            n_bad++;
            $display("[TB] FAIL b2b_count got %0d want >=1536", q0.size());
        end else begin
            for (int j = 0; j < 1536; j++) begin
                blk = j / 256;
                k   = j % 256;
                f   = blk / 2;
                er  = (blk % 2 == 0) ? 24'(k + 128 + 512 * f) : 24'(-128);
                ei  = (blk % 2 == 0) ? 24'(-f) : 24'd0;
                et  = (blk % 2 == 0) ? 8'd0 : 8'(k);
                n_cmp++;
                if ({q0[j].cyc, q0[j].r, q0[j].i, q0[j].d, q0[j].tw} !==
                    {c0 + 257 + j, er, ei, (blk % 2 == 1), et}) begin
                    n_bad++;
                    $display("[TB] FAIL b2b j=%0d got cyc=%0d r=%h i=%h d=%b tw=%0d want cyc=%0d r=%h i=%h tw=%0d",
                             j, q0[j].cyc - c0, q0[j].r, q0[j].i, q0[j].d, q0[j].tw, 257 + j, er, ei, et);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        int c0;
        do_reset();
        for (int n = 0; n < 300; n++) drive(1'b1, 24'(n + 5000), 24'd7);
        rst_n = 1'b0;
        drive(1'b0, '0, '0);
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_out_valid got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.dout_r !== '0) begin n_bad++; $display("[TB] FAIL midreset_dout_r got %h want 0", bus0.dout_r); end
        drive(1'b0, '0, '0);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        c0 = cyc;
        for (int n = 0; n < 512; n++) drive(1'b1, 24'(n), '0);
        repeat (260) drive(1'b0, '0, '0);
        check_ramp("midreset", c0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.din_r    = '0;
        bus0.din_i    = '0;
        test_reset();
        test_ramp();
        test_complex();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdf_r2_bf_stage256.md
Name: sdf_r2_bf_stage256

Overview:
- Radix-2 butterfly and control element for the N/2=256 stage of the 1024-point single-delay-feedback (SDF) FFT.
- Sits directly around the 256-deep complex delay line:
  - drives the delay line's input and valid;
  - consumes the delay line's output together with the upstream sample stream.
- Emits natural-stage butterfly results (sums, then differences) to the next stage.
- Flags which outputs need twiddle rotation and with which index.

Parameters:
- WIDTH, 24, bit width of each real/imag sample (two's complement).
- HALF, 256, butterfly span = delay line depth; must be a power of two.
- SCALE, 1, 1 = divide butterfly outputs by 2 (arithmetic shift right, truncate); 0 = keep low WIDTH bits (wrap).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  upstream sample valid
- din_r  in  WIDTH  upstream sample, real
- din_i  in  WIDTH  upstream sample, imag
- sr_dout_r  in  WIDTH  delay-line output, real
- sr_dout_i  in  WIDTH  delay-line output, imag
- sr_valid  out  1  delay-line shift enable
- sr_din_r  out  WIDTH  delay-line input, real
- sr_din_i  out  WIDTH  delay-line input, imag
- out_valid  out  1  dout valid
- dout_r  out  WIDTH  stage output, real
- dout_i  out  WIDTH  stage output, imag
- out_diff  out  1  1 = dout is a difference term (needs twiddle)
- tw_idx  out  log2(HALF)  twiddle index k for difference outputs, else 0

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All registers clear: cnt=0, run=0, out_valid=0, dout_r/i=0, out_diff=0, tw_idx=0. Reset mid-frame discards all state; the next in_valid starts frame alignment at cnt=0.
- Activity:
  - active = in_valid | run.
  - run sets on the first cycle in_valid=1 and stays set until reset (drains the last half frame).
  - While active, the delay line shifts each cycle: sr_valid = active, combinational.
- Input masking: din_eff = din when in_valid=1, else 0.
- Counter:
  - cnt has log2(2*HALF) = 9 bits and increments on every active cycle, wrapping 511 -> 0.
  - phase = cnt[8].
  - Nothing advances when active=0.
- Phase A (cnt < HALF):
  - sr_din = din_eff (store first-half sample).
  - Selected output = sr_dout, i.e. the difference written during the previous phase B; out_diff_next = 1; tw_idx_next = cnt[7:0].
- Phase B (cnt >= HALF):
  - sum = sr_dout + din_eff and diff = sr_dout - din_eff, computed at WIDTH+1 bits, real and imag independently.
  - SCALE=1: take bits [WIDTH:1]. SCALE=0: take bits [WIDTH-1:0].
  - Selected output = scaled sum; out_diff_next = 0; tw_idx_next = 0.
  - sr_din = scaled diff.
- Output register:
  - On each active cycle, dout/out_diff/tw_idx load the selected values.
  - out_valid loads (phase B) | primed; primed sets on the first phase-B cycle and stays set.
  - Phase-A outputs before the first phase B are garbage and are not flagged valid.
  - On an inactive cycle, out_valid=0 and dout holds.
- Latency:
  - Sample x[n+256] enters at cnt=256+n; the sum appears on dout the next cycle.
  - diff[n] appears 256 active cycles after it is written, plus 1 register cycle.
- Ordering per frame: 256 sums (k=0..255), then 256 differences (k=0..255).
- Gaps: in_valid may drop inside a frame while run=1. Zeros are then inserted and the frame alignment still advances; the upstream stage guarantees gapless frames.
- Overflow: SCALE=0 wraps silently; no saturation.

Test Plan:
- Reset state: hold rst_n=0 with in_valid=1 → out_valid=0, dout=0, sr_valid=0. Release → first valid output appears exactly 257 cycles after the first in_valid.
- Ramp frame, SCALE=1: x[n]=n real, imag 0, n=0..511 → out k=0 sum=128, diff=-128; k=255 sum=383, diff=-128; out_diff=0 for 256 samples then 1 with tw_idx 0..255.
- Complex constant: x=(1000,-2000) for all 512 samples, SCALE=1 → sums=(1000,-2000), diffs=(0,0).
- Overflow, SCALE=0: x[n]=0x7FFFFF for n<256 and 1 for n≥256 → sum=0x800000 (wrapped), diff=0x7FFFFE.
- Back-to-back frames: 3 continuous frames → continuous out_valid after the first 257 cycles. Frame-2 diffs are interleaved exactly before frame-3 sums; after in_valid falls, 256 drain diffs are emitted.
- Mid-frame reset: assert rst_n=0 at cnt=300 for 2 cycles, then a fresh frame → outputs match the fresh ramp results with no residue from the old frame.
